// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_pkg
//  Description : Shared types and constants for the DMA read arbiter:
//                engine-id width, in-flight tag layout and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package dec_pkg;

    // The id field is sized for the largest supported engine count (8), so
    // one tag layout serves every legal NUM_ENG value.
    localparam int MAX_ENG  = 8;
    localparam int ENG_ID_W = $clog2(MAX_ENG);
    localparam int LEN_W    = 8;

    // One accepted burst: owning engine and AXI length (beats-1).
    typedef struct packed {
        logic [ENG_ID_W-1:0] id;
        logic [LEN_W-1:0]    len;
    } rd_tag_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rd_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rd_tag_fifo
//  Description : Synchronous FIFO with first-word-fall-through head, used to
//                hold the owner/length tag of every accepted read burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    // Guard both ports so a stray push/pop can never corrupt the occupancy.
    assign w_wr_en = i_push && (r_count != CNT_W'(DEPTH));
    assign w_rd_en = i_pop  && (r_count != '0);

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rd_arbiter
//  Description : Round-robin sharing of one DMA read channel between NUM_ENG
//                engines; accepted bursts are tagged in order and returned
//                beats are steered to the owning engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rd_arbiter
    import dec_pkg::*;
#(
    parameter int NUM_ENG            = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_ENG-1:0]                      eng_rd_req,
    input  logic [NUM_ENG*C_M_AXI_ADDR_WIDTH-1:0]   eng_rd_addr,
    input  logic [NUM_ENG*8-1:0]                    eng_rd_len,
    output logic [NUM_ENG-1:0]                      eng_rd_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]           eng_rd_data,
    output logic [NUM_ENG-1:0]                      eng_rd_data_valid,
    input  logic [NUM_ENG-1:0]                      eng_rd_data_taken,
    output logic                                    dma_rd_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           dma_rd_addr,
    output logic [7:0]                              dma_rd_len,
    input  logic                                    dma_rd_req_ack,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]           dma_rd_data,
    input  logic                                    dma_rd_data_valid,
    output logic                                    dma_rd_data_taken,
    output logic [$clog2(MAX_OUTSTANDING):0]        outstanding,
    output logic                                    stray_data
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ENG_ID_W-1:0]   r_last_grant;
    logic [ENG_ID_W-1:0]   r_grant_id;
    logic [AW-1:0]         r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat_cnt;
    logic                  r_stray;

    logic [MAX_ENG-1:0]    w_req_pad;
    logic [MAX_ENG-1:0]    w_taken_pad;
    logic [ENG_ID_W-1:0]   w_idx;
    logic [ENG_ID_W-1:0]   w_win_id;
    logic                  w_win_vld;
    logic [AW-1:0]         w_win_addr;
    logic [7:0]            w_win_len;
    logic                  w_grant_load;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_beat;
    rd_tag_t               w_push_tag;
    rd_tag_t               w_head_tag;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_count;

    // Round-robin search: the first requester after last_grant, modulo NUM_ENG.
    // Iterating downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_ENG-1:0] = eng_rd_req;
        w_idx                  = '0;
        w_win_vld              = 1'b0;
        w_win_id               = '0;
        for (int k = NUM_ENG; k >= 1; k--) begin
            w_idx = ENG_ID_W'((int'(r_last_grant) + k) % NUM_ENG);
            if (w_req_pad[w_idx]) begin
                w_win_vld = 1'b1;
                w_win_id  = w_idx;
            end
        end
    end

    // Select the winning engine's address and length.
    always_comb begin
        w_win_addr = '0;
        w_win_len  = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (w_win_id == ENG_ID_W'(i)) begin
                w_win_addr = eng_rd_addr[i*AW +: AW];
                w_win_len  = eng_rd_len[i*8 +: 8];
            end
        end
    end

    // Next-state logic: grant only when a tag slot is free, push on DMA ack.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld && !w_fifo_full) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (dma_rd_req_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register plus the captured request, held stable while in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= ENG_ID_W'(NUM_ENG - 1);
            r_grant_id   <= '0;
            r_addr       <= '0;
            r_len        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_load) begin
                r_grant_id <= w_win_id;
                r_addr     <= w_win_addr;
                r_len      <= w_win_len;
            end
            if (w_push) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign w_push_tag = '{id: r_grant_id, len: r_len};

    rd_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(rd_tag_t))
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_tag),
        .i_pop   (w_pop),
        .o_dout  (w_head_tag),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    assign dma_rd_req  = (r_state == GRANT);
    assign dma_rd_addr = r_addr;
    assign dma_rd_len  = r_len;
    assign eng_rd_data = dma_rd_data;
    assign outstanding = w_count;
    assign stray_data  = r_stray;

    // Return-path steering: head tag owns both the valid and the flow control.
    always_comb begin
        w_taken_pad              = '0;
        w_taken_pad[NUM_ENG-1:0] = eng_rd_data_taken;
        eng_rd_req_ack           = '0;
        eng_rd_data_valid        = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_rd_req_ack[i]    = w_push && (r_grant_id == ENG_ID_W'(i));
            eng_rd_data_valid[i] = dma_rd_data_valid && !w_fifo_empty &&
                                   (w_head_tag.id == ENG_ID_W'(i));
        end
        dma_rd_data_taken = !w_fifo_empty && w_taken_pad[w_head_tag.id];
    end

    assign w_beat = dma_rd_data_valid && dma_rd_data_taken;
    assign w_pop  = w_beat && (r_beat_cnt == w_head_tag.len);

    // Beat counter within the head burst; wraps to zero when the burst retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Sticky flag for data arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stray <= 1'b0;
        end else if (dma_rd_data_valid && w_fifo_empty) begin
            r_stray <= 1'b1;
        end
    end

endmodule
`default_nettype wire
